// File: rtl/int_seq_pkg.sv
// Shared types and constants for the CPU-side interrupt sequencer.
package int_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_HANDLER = 2'd2,
    ST_RETURN  = 2'd3
  } state_t;

  localparam int          INT_ID_W            = 8;
  localparam logic [31:0] DEFAULT_VECTOR_ADDR = 32'h0000_0001;

endpackage

// File: rtl/int_sequencer.sv
// Interrupt entry/return sequencer: saves resume PC, redirects fetch to the vector and back on reti.
// Outputs are registered one edge after the triggering input; redirects hold until redirect_ready.
// Optional INT_SEQ_CAUSE_EN keeps a register of the serviced interrupt ID on int_cause.
module int_sequencer
  import int_seq_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] VECTOR_ADDR = ADDR_W'(DEFAULT_VECTOR_ADDR)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                intCPU,
  input  logic [INT_ID_W-1:0] intID,
  input  logic                safe_point,
  input  logic [ADDR_W-1:0]   resume_pc,
  input  logic                reti,
  input  logic                redirect_ready,
  output logic                intDisabled,
  output logic                redirect_valid,
  output logic [ADDR_W-1:0]   redirect_pc,
  output logic [ADDR_W-1:0]   epc,
  output logic                reti_err,
  output logic [INT_ID_W-1:0] int_cause
);

  state_t state;
  logic   take_int;

  assign take_int = (state == ST_IDLE) && intCPU && safe_point;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      intDisabled    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      epc            <= '0;
      reti_err       <= 1'b0;
    end else begin
      reti_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A reti here is stray even when it coincides with a taken interrupt.
          if (reti) reti_err <= 1'b1;
          if (take_int) begin
            epc            <= resume_pc;
            redirect_pc    <= VECTOR_ADDR;
            redirect_valid <= 1'b1;
            intDisabled    <= 1'b1;
            state          <= ST_ENTER;
          end
        end
        ST_ENTER: begin
          if (reti) reti_err <= 1'b1;
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            state          <= ST_HANDLER;
          end
        end
        ST_HANDLER: begin
          if (reti) begin
            redirect_pc    <= epc;
            redirect_valid <= 1'b1;
            state          <= ST_RETURN;
          end
        end
        ST_RETURN: begin
          if (reti) reti_err <= 1'b1;
          // Unmask only once the return redirect is accepted, so a queued request waits.
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            intDisabled    <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: begin
          state          <= ST_IDLE;
          intDisabled    <= 1'b0;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef INT_SEQ_CAUSE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        int_cause <= '0;
    else if (take_int) int_cause <= intID;
  end
`else
  logic unused_int_id;
  assign unused_int_id = ^intID;
  assign int_cause     = '0;
`endif

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: directed vector table, async reset case, then random stimulus vs a flag-based model.
module tb_int_sequencer;
  import int_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        intCPU;
  logic [7:0]  intID;
  logic        safe_point;
  logic [31:0] resume_pc;
  logic        reti;
  logic        redirect_ready;
  logic        intDisabled;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic        reti_err;
  logic [7:0]  int_cause;

  int n_vec  = 0;
  int n_miss = 0;

  int_sequencer dut (
    .clk(clk), .reset(reset), .intCPU(intCPU), .intID(intID),
    .safe_point(safe_point), .resume_pc(resume_pc), .reti(reti),
    .redirect_ready(redirect_ready), .intDisabled(intDisabled),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .epc(epc),
    .reti_err(reti_err), .int_cause(int_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        icpu;
    logic [7:0]  id;
    logic        sp;
    logic [31:0] rpc;
    logic        rt;
    logic        rdy;
    logic        e_dis;
    logic        e_val;
    logic [31:0] e_rpc;
    logic [31:0] e_epc;
    logic        e_err;
    logic [7:0]  e_cause;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] ec(input logic [7:0] id);
`ifdef INT_SEQ_CAUSE_EN
    return id;
`else
    return 8'd0;
`endif
  endfunction

  task automatic add(input logic icpu, input logic [7:0] id, input logic sp, input logic [31:0] rpc,
                     input logic rt, input logic rdy, input logic e_dis, input logic e_val,
                     input logic [31:0] e_rpc, input logic [31:0] e_epc, input logic e_err,
                     input logic [7:0] e_cause_id);
    vec_t v;
    v.icpu = icpu; v.id = id; v.sp = sp; v.rpc = rpc; v.rt = rt; v.rdy = rdy;
    v.e_dis = e_dis; v.e_val = e_val; v.e_rpc = e_rpc; v.e_epc = e_epc;
    v.e_err = e_err; v.e_cause = ec(e_cause_id);
    vecs.push_back(v);
  endtask

  task automatic check(input string tag, input logic e_dis, input logic e_val, input logic [31:0] e_rpc,
                       input logic [31:0] e_epc, input logic e_err, input logic [7:0] e_cause);
    n_vec++;
    if (intDisabled !== e_dis) begin
      n_miss++; $display("FAIL %s intDisabled got %0b want %0b", tag, intDisabled, e_dis);
    end
    if (redirect_valid !== e_val) begin
      n_miss++; $display("FAIL %s redirect_valid got %0b want %0b", tag, redirect_valid, e_val);
    end
    if (e_val && redirect_pc !== e_rpc || !e_val && redirect_pc !== e_rpc) begin
      n_miss++; $display("FAIL %s redirect_pc got %h want %h", tag, redirect_pc, e_rpc);
    end
    if (epc !== e_epc) begin
      n_miss++; $display("FAIL %s epc got %h want %h", tag, epc, e_epc);
    end
    if (reti_err !== e_err) begin
      n_miss++; $display("FAIL %s reti_err got %0b want %0b", tag, reti_err, e_err);
    end
    if (int_cause !== e_cause) begin
      n_miss++; $display("FAIL %s int_cause got %h want %h", tag, int_cause, e_cause);
    end
  endtask

  task automatic drive(input logic icpu, input logic [7:0] id, input logic sp, input logic [31:0] rpc,
                       input logic rt, input logic rdy);
    intCPU = icpu; intID = id; safe_point = sp; resume_pc = rpc; reti = rt; redirect_ready = rdy;
  endtask

  // Reference model: "busy" spans entry to completed return, "pend" marks an outstanding redirect,
  // "ret" says whether that redirect is the return one.
  logic        m_busy, m_pend, m_ret, m_err;
  logic [31:0] m_epc, m_rpc;
  logic [7:0]  m_cause;

  task automatic model_reset();
    m_busy = 0; m_pend = 0; m_ret = 0; m_err = 0; m_epc = 0; m_rpc = 0; m_cause = 0;
  endtask

  task automatic model_step();
    m_err = 0;
    if (!m_busy) begin
      if (reti) m_err = 1;
      if (intCPU && safe_point) begin
        m_busy = 1; m_pend = 1; m_ret = 0;
        m_epc = resume_pc; m_rpc = 32'h1; m_cause = intID;
      end
    end else if (m_pend) begin
      if (reti) m_err = 1;
      if (redirect_ready) begin
        m_pend = 0;
        if (m_ret) m_busy = 0;
      end
    end else if (reti) begin
      m_pend = 1; m_ret = 1; m_rpc = m_epc;
    end
  endtask

  task automatic model_check(input string tag);
    check(tag, m_busy, m_pend, m_rpc, m_epc, m_err, ec(m_cause));
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    //   icpu id sp  rpc      rt rdy   dis val rpc_out   epc      err cause
    add(1, 3, 1, 32'h100, 0, 1,   1, 1, 32'h1,   32'h100, 0, 3);
    add(1, 3, 1, 32'h104, 0, 1,   1, 0, 32'h1,   32'h100, 0, 3);
    add(0, 0, 0, 32'h0,   0, 1,   1, 0, 32'h1,   32'h100, 0, 3);
    add(1, 5, 1, 32'h200, 0, 1,   1, 0, 32'h1,   32'h100, 0, 3);
    add(1, 5, 1, 32'h200, 1, 0,   1, 1, 32'h100, 32'h100, 0, 3);
    add(1, 5, 1, 32'h204, 0, 1,   0, 0, 32'h100, 32'h100, 0, 3);
    add(0, 5, 1, 32'h208, 0, 0,   0, 0, 32'h100, 32'h100, 0, 3);
    add(1, 5, 1, 32'h300, 0, 0,   1, 1, 32'h1,   32'h300, 0, 5);
    for (int i = 0; i < 4; i++)
      add(1, 5, 1, 32'h304, 0, 0, 1, 1, 32'h1,   32'h300, 0, 5);
    add(0, 0, 0, 32'h0,   0, 1,   1, 0, 32'h1,   32'h300, 0, 5);
    add(0, 0, 0, 32'h0,   1, 1,   1, 1, 32'h300, 32'h300, 0, 5);
    add(0, 0, 0, 32'h0,   1, 0,   1, 1, 32'h300, 32'h300, 1, 5);
    add(0, 0, 0, 32'h0,   0, 1,   0, 0, 32'h300, 32'h300, 0, 5);
    for (int i = 0; i < 5; i++)
      add(1, 7, 0, 32'h400 + 32'(4 * i), 0, 1, 0, 0, 32'h300, 32'h300, 0, 5);
    add(1, 7, 1, 32'h414, 0, 0,   1, 1, 32'h1,   32'h414, 0, 7);
    add(0, 0, 0, 32'h0,   1, 0,   1, 1, 32'h1,   32'h414, 1, 7);
    add(0, 0, 0, 32'h0,   0, 1,   1, 0, 32'h1,   32'h414, 0, 7);
    add(0, 0, 0, 32'h0,   1, 0,   1, 1, 32'h414, 32'h414, 0, 7);
    add(0, 0, 0, 32'h0,   0, 1,   0, 0, 32'h414, 32'h414, 0, 7);
    add(0, 0, 0, 32'h0,   1, 0,   0, 0, 32'h414, 32'h414, 1, 7);
    add(0, 0, 0, 32'h0,   0, 0,   0, 0, 32'h414, 32'h414, 0, 7);
    add(1, 2, 1, 32'h500, 1, 0,   1, 1, 32'h1,   32'h500, 1, 2);
    add(0, 0, 0, 32'h0,   0, 1,   1, 0, 32'h1,   32'h500, 0, 2);
    add(0, 0, 0, 32'h0,   1, 0,   1, 1, 32'h500, 32'h500, 0, 2);
    add(0, 0, 0, 32'h0,   0, 1,   0, 0, 32'h500, 32'h500, 0, 2);
    add(1, 4, 1, 32'h100, 0, 0,   1, 1, 32'h1,   32'h100, 0, 4);
    add(0, 0, 0, 32'h0,   0, 1,   1, 0, 32'h1,   32'h100, 0, 4);

    repeat (3) @(posedge clk);
    #1 check("reset_state", 0, 0, 32'h0, 32'h0, 0, 8'h0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 check("idle_after_reset", 0, 0, 32'h0, 32'h0, 0, 8'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].icpu, vecs[i].id, vecs[i].sp, vecs[i].rpc, vecs[i].rt, vecs[i].rdy);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), vecs[i].e_dis, vecs[i].e_val, vecs[i].e_rpc,
               vecs[i].e_epc, vecs[i].e_err, vecs[i].e_cause);
    end

    // Async reset while in HANDLER with epc=0x100: outputs clear without a clock edge.
    drive(1, 6, 1, 32'h700, 0, 1);
    #2 reset = 1'b0;
    #1 check("async_rst_handler", 0, 0, 32'h0, 32'h0, 0, 8'h0);
    @(posedge clk);
    #1 check("held_in_reset", 0, 0, 32'h0, 32'h0, 0, 8'h0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk) reset = 1'b1;

    model_reset();
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(1, 8)), 1'($urandom_range(0, 1)),
            $urandom, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
      @(posedge clk);
      model_step();
      #1 model_check("rand");
      if ($urandom_range(0, 149) == 0) begin
        #2 reset = 1'b0;
        model_reset();
        #1 model_check("rand_async_rst");
        @(negedge clk) reset = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/int_sequencer.md
# int_sequencer

CPU-side end of the interrupt request interface: accepts the registered `intCPU`/`intID` request from the interrupt controller, drives `intDisabled` back as the acknowledge, saves the resume PC and redirects fetch to the interrupt vector. On `reti` it redirects fetch back to the saved PC and then re-enables interrupts. It sits between the interrupt controller and the CPU fetch/branch-redirect logic.

## Interface
- `ADDR_W`, 32, width of PCs
- `VECTOR_ADDR`, 1, handler entry address (`ADDR_W` bits)
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-low; clears all state
- `intCPU` in 1: interrupt request from the controller
- `intID` in 8: interrupt ID, valid while `intCPU`=1 (1..8)
- `safe_point` in 1: the pipeline is at an instruction boundary and can be interrupted this cycle
- `resume_pc` in `ADDR_W`: PC to resume at if interrupted this cycle
- `reti` in 1: `reti` commits this cycle (single-cycle pulse)
- `redirect_ready` in 1: fetch accepts the redirect
- `intDisabled` out 1: interrupts masked; also the acknowledge to the controller
- `redirect_valid` out 1: fetch redirect request
- `redirect_pc` out `ADDR_W`: redirect target
- `epc` out `ADDR_W`: saved resume PC
- `reti_err` out 1: one-cycle pulse when `reti` arrives outside a handler
- `int_cause` out 8: ID of the interrupt being serviced (see Configuration)

## Operation
- States: IDLE, ENTER, HANDLER, RETURN.
- IDLE:
  - `intDisabled`=0.
  - If `intCPU & safe_point`: latch `epc<=resume_pc`, `int_cause<=intID`, `redirect_pc<=VECTOR_ADDR`, then go to ENTER.
  - `intCPU` without `safe_point`: wait; the request stays pending because the controller holds it.
  - `reti` in IDLE: ignored, and `reti_err` pulses.
- ENTER:
  - `intDisabled`=1 and `redirect_valid`=1.
  - Hold until `redirect_ready`=1, then go to HANDLER.
- HANDLER:
  - `intDisabled`=1.
  - `intCPU` is ignored.
  - On `reti`: set `redirect_pc<=epc` and go to RETURN.
- RETURN:
  - `intDisabled`=1 and `redirect_valid`=1.
  - Hold until `redirect_ready`, then go to IDLE.
  - `reti` in ENTER or RETURN: ignored, and `reti_err` pulses.
- Simultaneous events:
  - In IDLE, `intCPU & safe_point` together with `reti`: the interrupt is taken and `reti_err` pulses.
  - `redirect_ready` asserted while `redirect_valid`=0 has no effect.
- All outputs are registered.

## Timing
- Reset values: state=IDLE, `intDisabled`=0, `redirect_valid`=0, `redirect_pc`=0, `epc`=0, `reti_err`=0, `int_cause`=0.
- Entry:
  - Request sampled at edge N.
  - From N+1: `intDisabled`=1 and `redirect_valid`=1 with `redirect_pc=VECTOR_ADDR`.
  - The controller drops `intCPU` from N+2.
- Redirect handshake:
  - The redirect completes on the first edge where `redirect_valid & redirect_ready`.
  - `redirect_valid` deasserts the cycle after that edge.
  - `redirect_pc` is stable while `redirect_valid`=1.
- Return:
  - `reti` at edge M gives `redirect_valid`=1 with `redirect_pc=epc` from M+1.
  - With `redirect_ready` high at M+1, `intDisabled`=0 from M+2.
  - A queued interrupt is therefore never taken before the return redirect completes.
- Minimum back-to-back: return completes at M+1; the controller re-raises `intCPU` at M+3 at the earliest; the next entry is sampled at M+3.
- Reset asserted mid-ENTER/HANDLER/RETURN: immediately returns to reset values; the pending redirect is dropped.

## Configuration
- `INT_SEQ_CAUSE_EN` defined: `int_cause` latches `intID` on entry and holds it until the next entry.
- `INT_SEQ_CAUSE_EN` undefined: `int_cause` tied to 0 and no register is inferred.

## Structure
- Shared package `int_seq_pkg`:
  - state encoding (IDLE=0, ENTER=1, HANDLER=2, RETURN=3);
  - default `VECTOR_ADDR` constant;
  - interrupt ID width (8).
- Single module; no sub-module. The redirect hold logic is small enough to stay inline.

## Test plan
- Reset low, then high; `intCPU`=1, `intID`=3, `safe_point`=1, `resume_pc`=0x100, `redirect_ready`=1 at N -> at N+1 `intDisabled`=1, `redirect_valid`=1, `redirect_pc`=1; `epc`=0x100; `int_cause`=3 (macro on) or 0 (macro off).
- `intCPU`=1 with `safe_point`=0 for 5 cycles, then 1 -> no entry until `safe_point`; `epc` equals `resume_pc` of the accepting cycle.
- `redirect_ready`=0 for 4 cycles in ENTER -> `redirect_valid` and `redirect_pc` held; HANDLER entered the edge after `redirect_ready`=1.
- In HANDLER, `reti` at M -> `redirect_pc`=0x100 at M+1, `intDisabled`=0 at M+2; with a second interrupt queued in the controller, re-entry at M+3 saves the new `resume_pc`.
- `reti` pulse in IDLE -> `reti_err`=1 for one cycle; state, `epc` and `intDisabled` unchanged.
- Reset asserted in HANDLER with `epc`=0x100 -> asynchronously `intDisabled`=0, `epc`=0, `redirect_valid`=0.
